// File: rtl/rat_alu_pipe_if.sv
// Handshake and data bundle between decode (master) and the RAT ALU stage (slave).
interface rat_alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flg_we;
  logic             c_set;
  logic             c_clr;
  logic             flg_save;
  logic             flg_restore;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             out_wr;
  logic             c_flag;
  logic             z_flag;

  modport master (
    output in_valid, sel, a, b, flg_we, c_set, c_clr, flg_save, flg_restore, out_ready,
    input  in_ready, out_valid, result, out_wr, c_flag, z_flag
  );

  modport slave (
    input  in_valid, sel, a, b, flg_we, c_set, c_clr, flg_save, flg_restore, out_ready,
    output in_ready, out_valid, result, out_wr, c_flag, z_flag
  );
endinterface

// File: rtl/rat_alu_pipe.sv
// RAT ALU with one registered output stage, internal C/Z flags and an
// interrupt shadow copy of the flags. Carry-in always comes from the held C.
module rat_alu_pipe #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  rat_alu_pipe_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_ADDC = 4'd1,  OP_SUB  = 4'd2,  OP_SUBC = 4'd3,
    OP_CMP  = 4'd4,  OP_AND  = 4'd5,  OP_OR   = 4'd6,  OP_EXOR = 4'd7,
    OP_TEST = 4'd8,  OP_LSL  = 4'd9,  OP_LSR  = 4'd10, OP_ROL  = 4'd11,
    OP_ROR  = 4'd12, OP_ASR  = 4'd13, OP_MOV  = 4'd14, OP_RSVD = 4'd15
  } op_e;

  localparam int N = WIDTH - 1;

  logic             r_c;
  logic             r_z;
  logic             r_sh_c;
  logic             r_sh_z;
  logic             r_out_valid;
  logic             r_out_wr;
  logic [WIDTH-1:0] r_result;

  logic             w_in_ready;
  logic             w_accept;
  op_e              w_op;
  logic [WIDTH:0]   w_cin_ext;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_addc;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_subc;
  logic [WIDTH-1:0] w_res;
  logic             w_c_op;
  logic             w_z_op;
  logic             w_wr;
  logic             w_flag_op;
  logic             w_c_next;
  logic             w_z_next;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_op       = op_e'(bus.sel);

  // Arithmetic is one bit wider so bit WIDTH is carry (add) or borrow (sub).
  assign w_cin_ext = {{WIDTH{1'b0}}, r_c};
  assign w_add     = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_addc    = w_add + w_cin_ext;
  assign w_sub     = {1'b0, bus.a} - {1'b0, bus.b};
  assign w_subc    = w_sub - w_cin_ext;

  // Opcode decode: result, carry from the op, write-back and flag-affecting qualifiers.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_res     = bus.a;
    w_c_op    = 1'b0;
    w_wr      = 1'b1;
    w_flag_op = 1'b1;
    unique case (w_op)
      OP_ADD:  begin w_res = w_add[N:0];  w_c_op = w_add[WIDTH];  end
      OP_ADDC: begin w_res = w_addc[N:0]; w_c_op = w_addc[WIDTH]; end
      OP_SUB:  begin w_res = w_sub[N:0];  w_c_op = w_sub[WIDTH];  end
      OP_SUBC: begin w_res = w_subc[N:0]; w_c_op = w_subc[WIDTH]; end
      OP_CMP:  begin w_res = w_sub[N:0];  w_c_op = w_sub[WIDTH];  w_wr = 1'b0; end
      OP_AND:  w_res = bus.a & bus.b;
      OP_OR:   w_res = bus.a | bus.b;
      OP_EXOR: w_res = bus.a ^ bus.b;
      OP_TEST: begin w_res = bus.a & bus.b; w_wr = 1'b0; end
      OP_LSL:  begin w_res = {bus.a[N-1:0], r_c};    w_c_op = bus.a[N]; end
      OP_LSR:  begin w_res = {r_c, bus.a[N:1]};      w_c_op = bus.a[0]; end
      OP_ROL:  begin w_res = {bus.a[N-1:0], bus.a[N]}; w_c_op = bus.a[N]; end
      OP_ROR:  begin w_res = {bus.a[0], bus.a[N:1]}; w_c_op = bus.a[0]; end
      OP_ASR:  begin w_res = {bus.a[N], bus.a[N:1]}; w_c_op = bus.a[0]; end
      OP_MOV:  begin w_res = bus.b; w_flag_op = 1'b0; end
      OP_RSVD: begin w_res = bus.a; w_flag_op = 1'b0; w_wr = 1'b0; end
      default: begin w_res = bus.a; w_flag_op = 1'b0; w_wr = 1'b0; end
    endcase
  end

  assign w_z_op = (w_res == '0);

  // Next flag values; later assignments override earlier ones, giving the priority order.
  always_comb begin
    w_c_next = r_c;
    w_z_next = r_z;
    if (w_accept && bus.flg_we && w_flag_op) begin
      w_c_next = w_c_op;
      w_z_next = w_z_op;
    end
    if (bus.c_set) begin
      w_c_next = 1'b1;
    end else if (bus.c_clr) begin
      w_c_next = 1'b0;
    end
    if (bus.flg_restore) begin
      w_c_next = r_sh_c;
      w_z_next = r_sh_z;
    end
  end

  // Flag and shadow registers; save samples the pre-edge flags, so save+restore swaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c    <= 1'b0;
      r_z    <= 1'b0;
      r_sh_c <= 1'b0;
      r_sh_z <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make every register here read the old r_c/r_z.
      r_c <= w_c_next;
      r_z <= w_z_next;
      if (bus.flg_save) begin
        r_sh_c <= r_c;
        r_sh_z <= r_z;
      end
    end
  end

  // Output stage: load on accept, drop valid when drained without a replacement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_out_wr    <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_out_wr    <= w_wr;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.out_wr    = r_out_wr;
  assign bus.c_flag    = r_c;
  assign bus.z_flag    = r_z;

endmodule

// File: tb/tb_rat_alu_pipe.sv
// Directed bench for rat_alu_pipe: an 8-bit instance for most scenarios and a
// 16-bit instance for the wide-carry case.
module tb_rat_alu_pipe;

  localparam logic [3:0] ADD = 4'd0, ADDC = 4'd1, SUB = 4'd2, CMP = 4'd4,
                         EXOR = 4'd7, TEST = 4'd8, LSL = 4'd9, LSR = 4'd10,
                         ROL = 4'd11, ASR = 4'd13, MOV = 4'd14, RSVD = 4'd15;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rat_alu_pipe_if #(.WIDTH(8))  bus8 ();
  rat_alu_pipe_if #(.WIDTH(16)) bus16 ();

  rat_alu_pipe #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  rat_alu_pipe #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] s, input logic [7:0] aa,
                       input logic [7:0] bb, input logic we);
    bus8.in_valid = v;
    bus8.sel      = s;
    bus8.a        = aa;
    bus8.b        = bb;
    bus8.flg_we   = we;
  endtask

  task automatic ctl(input logic cs, input logic cc, input logic sv, input logic rs);
    bus8.c_set       = cs;
    bus8.c_clr       = cc;
    bus8.flg_save    = sv;
    bus8.flg_restore = rs;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus8.out_valid); end
    checks++; if (bus8.result !== 8'h00) begin errors++; $display("FAIL rst_result: got %h want 00", bus8.result); end
    checks++; if (bus8.out_wr !== 1'b0) begin errors++; $display("FAIL rst_wr: got %b want 0", bus8.out_wr); end
    checks++; if ({bus8.c_flag, bus8.z_flag} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b want 00", {bus8.c_flag, bus8.z_flag}); end
    checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus8.in_ready); end
    checks++; if (bus16.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid16: got %b want 0", bus16.out_valid); end
    rst_n = 1'b1;
  endtask

  task automatic test_add_addc();
    bus8.out_ready = 1'b1;
    drive(1'b1, ADD, 8'hAA, 8'hAA, 1'b1);
    tick();
    checks++; if (bus8.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", bus8.out_valid); end
    checks++; if (bus8.result !== 8'h54) begin errors++; $display("FAIL add_result: got %h want 54", bus8.result); end
    checks++; if ({bus8.c_flag, bus8.z_flag} !== 2'b10) begin errors++; $display("FAIL add_flags: got %b want 10", {bus8.c_flag, bus8.z_flag}); end
    checks++; if (bus8.out_wr !== 1'b1) begin errors++; $display("FAIL add_wr: got %b want 1", bus8.out_wr); end
    drive(1'b1, ADDC, 8'hC8, 8'h36, 1'b1);
    tick();
    checks++; if (bus8.result !== 8'hFF) begin errors++; $display("FAIL addc_result: got %h want FF", bus8.result); end
    checks++; if ({bus8.c_flag, bus8.z_flag} !== 2'b00) begin errors++; $display("FAIL addc_flags: got %b want 00", {bus8.c_flag, bus8.z_flag}); end
    drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
    tick();
    checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL addc_drain: got %b want 0", bus8.out_valid); end
  endtask

  task automatic test_sub_cmp();
    drive(1'b1, SUB, 8'h64, 8'hC8, 1'b1);
    tick();
    checks++; if (bus8.result !== 8'h9C) begin errors++; $display("FAIL sub_result: got %h want 9C", bus8.result); end
    checks++; if ({bus8.c_flag, bus8.z_flag} !== 2'b10) begin errors++; $display("FAIL sub_flags: got %b want 10", {bus8.c_flag, bus8.z_flag}); end
    drive(1'b1, CMP, 8'hAA, 8'hAA, 1'b1);
    tick();
    checks++; if ({bus8.c_flag, bus8.z_flag} !== 2'b01) begin errors++; $display("FAIL cmp_flags: got %b want 01", {bus8.c_flag, bus8.z_flag}); end
    checks++; if (bus8.out_wr !== 1'b0) begin errors++; $display("FAIL cmp_wr: got %b want 0", bus8.out_wr); end
    checks++; if (bus8.result !== 8'h00) begin errors++; $display("FAIL cmp_result: got %h want 00", bus8.result); end
    drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    bus8.out_ready = 1'b0;
    drive(1'b1, ADD, 8'h01, 8'h02, 1'b0);
    tick();
    checks++; if (bus8.result !== 8'h03 || bus8.out_valid !== 1'b1) begin errors++; $display("FAIL stall_first: got %h/%b want 03/1", bus8.result, bus8.out_valid); end
    drive(1'b1, ADD, 8'h10, 8'h20, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus8.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %b want 0", i, bus8.in_ready); end
      tick();
      checks++; if (bus8.result !== 8'h03) begin errors++; $display("FAIL stall_hold%0d: got %h want 03", i, bus8.result); end
    end
    bus8.out_ready = 1'b1;
    #1;
    checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL drain_ready: got %b want 1", bus8.in_ready); end
    tick();
    checks++; if (bus8.result !== 8'h30 || bus8.out_valid !== 1'b1) begin errors++; $display("FAIL drain_next: got %h/%b want 30/1", bus8.result, bus8.out_valid); end
    drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
    tick();
    checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL no_duplicate: got %b want 0", bus8.out_valid); end
    checks++; if ({bus8.c_flag, bus8.z_flag} !== 2'b01) begin errors++; $display("FAIL stall_flags_kept: got %b want 01", {bus8.c_flag, bus8.z_flag}); end
  endtask

  task automatic test_flags();
    drive(1'b1, ADD, 8'hAA, 8'hAA, 1'b1);
    tick();
    drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
    ctl(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, EXOR, 8'hAA, 8'hAA, 1'b1);
    ctl(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++; if ({bus8.c_flag, bus8.z_flag} !== 2'b01) begin errors++; $display("FAIL clr_exor_flags: got %b want 01", {bus8.c_flag, bus8.z_flag}); end
    drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
    ctl(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++; if ({bus8.c_flag, bus8.z_flag} !== 2'b10) begin errors++; $display("FAIL restore_flags: got %b want 10", {bus8.c_flag, bus8.z_flag}); end
    ctl(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++; if (bus8.c_flag !== 1'b0) begin errors++; $display("FAIL clc: got %b want 0", bus8.c_flag); end
    drive(1'b1, 4'd2, 8'h05, 8'h01, 1'b1);
    ctl(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checks++; if ({bus8.c_flag, bus8.z_flag} !== 2'b10 || bus8.result !== 8'h04) begin errors++; $display("FAIL set_over_op: got %b/%h want 10/04", {bus8.c_flag, bus8.z_flag}, bus8.result); end
    drive(1'b1, EXOR, 8'hAA, 8'hAA, 1'b1);
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
    ctl(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    checks++; if ({bus8.c_flag, bus8.z_flag} !== 2'b10) begin errors++; $display("FAIL swap_flags: got %b want 10", {bus8.c_flag, bus8.z_flag}); end
    ctl(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++; if ({bus8.c_flag, bus8.z_flag} !== 2'b01) begin errors++; $display("FAIL swap_shadow: got %b want 01", {bus8.c_flag, bus8.z_flag}); end
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_shifts();
    ctl(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus8.c_flag !== 1'b1) begin errors++; $display("FAIL sec: got %b want 1", bus8.c_flag); end
    drive(1'b1, LSR, 8'h80, 8'h00, 1'b1);
    tick();
    checks++; if (bus8.result !== 8'hC0 || bus8.c_flag !== 1'b0) begin errors++; $display("FAIL lsr: got %h/%b want C0/0", bus8.result, bus8.c_flag); end
    drive(1'b1, ROL, 8'hAA, 8'h00, 1'b1);
    tick();
    checks++; if (bus8.result !== 8'h55 || bus8.c_flag !== 1'b1) begin errors++; $display("FAIL rol: got %h/%b want 55/1", bus8.result, bus8.c_flag); end
    drive(1'b1, ASR, 8'h80, 8'h00, 1'b1);
    tick();
    checks++; if (bus8.result !== 8'hC0 || bus8.c_flag !== 1'b0) begin errors++; $display("FAIL asr: got %h/%b want C0/0", bus8.result, bus8.c_flag); end
    drive(1'b1, LSL, 8'h81, 8'h00, 1'b1);
    tick();
    checks++; if (bus8.result !== 8'h02 || bus8.c_flag !== 1'b1) begin errors++; $display("FAIL lsl: got %h/%b want 02/1", bus8.result, bus8.c_flag); end
    drive(1'b1, MOV, 8'hFF, 8'h00, 1'b1);
    tick();
    checks++; if (bus8.result !== 8'h00 || {bus8.c_flag, bus8.z_flag} !== 2'b10 || bus8.out_wr !== 1'b1) begin errors++; $display("FAIL mov: got %h/%b%b/%b want 00/10/1", bus8.result, bus8.c_flag, bus8.z_flag, bus8.out_wr); end
    drive(1'b1, RSVD, 8'h33, 8'h00, 1'b1);
    tick();
    checks++; if (bus8.result !== 8'h33 || bus8.out_wr !== 1'b0 || {bus8.c_flag, bus8.z_flag} !== 2'b10) begin errors++; $display("FAIL rsvd: got %h/%b/%b%b want 33/0/10", bus8.result, bus8.out_wr, bus8.c_flag, bus8.z_flag); end
    drive(1'b1, TEST, 8'h0F, 8'hF0, 1'b1);
    tick();
    checks++; if (bus8.out_wr !== 1'b0 || {bus8.c_flag, bus8.z_flag} !== 2'b01) begin errors++; $display("FAIL test_op: got %b/%b%b want 0/01", bus8.out_wr, bus8.c_flag, bus8.z_flag); end
    drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid();
    ctl(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, ADD, 8'hAA, 8'hAA, 1'b1);
    tick();
    drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
    checks++; if (bus8.out_valid !== 1'b1 || bus8.c_flag !== 1'b1) begin errors++; $display("FAIL pre_reset: got %b/%b want 1/1", bus8.out_valid, bus8.c_flag); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus8.out_valid !== 1'b0 || bus8.result !== 8'h00) begin errors++; $display("FAIL async_rst_out: got %b/%h want 0/00", bus8.out_valid, bus8.result); end
    checks++; if ({bus8.c_flag, bus8.z_flag} !== 2'b00) begin errors++; $display("FAIL async_rst_flags: got %b want 00", {bus8.c_flag, bus8.z_flag}); end
    tick();
    rst_n = 1'b1;
    ctl(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if ({bus8.c_flag, bus8.z_flag} !== 2'b00) begin errors++; $display("FAIL rst_shadow: got %b want 00", {bus8.c_flag, bus8.z_flag}); end
  endtask

  task automatic test_width16();
    bus16.out_ready = 1'b1;
    bus16.in_valid  = 1'b1;
    bus16.sel       = ADD;
    bus16.a         = 16'hFFFF;
    bus16.b         = 16'h0001;
    bus16.flg_we    = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    checks++; if (bus16.result !== 16'h0000 || bus16.out_valid !== 1'b1) begin errors++; $display("FAIL w16_result: got %h/%b want 0000/1", bus16.result, bus16.out_valid); end
    checks++; if ({bus16.c_flag, bus16.z_flag} !== 2'b11) begin errors++; $display("FAIL w16_flags: got %b want 11", {bus16.c_flag, bus16.z_flag}); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    bus8.out_ready     = 1'b0;
    bus16.in_valid     = 1'b0;
    bus16.sel          = 4'd0;
    bus16.a            = '0;
    bus16.b            = '0;
    bus16.flg_we       = 1'b0;
    bus16.c_set        = 1'b0;
    bus16.c_clr        = 1'b0;
    bus16.flg_save     = 1'b0;
    bus16.flg_restore  = 1'b0;
    bus16.out_ready    = 1'b0;
    test_reset();
    test_add_addc();
    test_sub_cmp();
    test_back_to_back();
    test_flags();
    test_shifts();
    test_reset_mid();
    test_width16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
